// File: rtl/scalu_rs_pkg.sv
// Shared widths, entry types and wakeup helpers for the scalar-ALU reservation station.
package scalu_rs_pkg;
  localparam int ROBID_W = 7;
  localparam int RD_W    = 6;
  localparam int OP_W    = 5;
  localparam int XLEN    = 32;

  typedef struct packed {
    logic               rdy;
    logic [ROBID_W-1:0] tag;
    logic [XLEN-1:0]    val;
  } rs_src_t;

  typedef struct packed {
    logic               valid;
    logic [OP_W-1:0]    op;
    logic [ROBID_W-1:0] robid;
    logic [RD_W-1:0]    rd;
    rs_src_t            src1;
    rs_src_t            src2;
  } rs_entry_t;

  // A pending source captures the broadcast value when its producer tag matches.
  function automatic rs_src_t wake_src(input rs_src_t s, input logic wb_valid,
                                       input logic [ROBID_W-1:0] wb_robid,
                                       input logic [XLEN-1:0] wb_result);
    rs_src_t n = s;
    if (wb_valid && !s.rdy && s.tag == wb_robid) begin
      n.rdy = 1'b1;
      n.val = wb_result;
    end
    return n;
  endfunction

  function automatic rs_entry_t step_entry(input rs_entry_t e, input logic free,
                                           input logic wb_valid,
                                           input logic [ROBID_W-1:0] wb_robid,
                                           input logic [XLEN-1:0] wb_result);
    rs_entry_t n = e;
    n.valid = e.valid & ~free;
    n.src1  = wake_src(e.src1, wb_valid, wb_robid, wb_result);
    n.src2  = wake_src(e.src2, wb_valid, wb_robid, wb_result);
    return n;
  endfunction
endpackage

// File: rtl/scalu_rs_age.sv
// Age matrix: row i bit j set means entry i is older than entry j; grants the oldest ready entry.
module scalu_rs_age
  import scalu_rs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] i_alloc_oh,
  input  logic [DEPTH-1:0] i_free_oh,
  input  logic [DEPTH-1:0] i_ready,
  output logic [DEPTH-1:0] o_grant
);
  logic [DEPTH-1:0][DEPTH-1:0] r_age;

  // A new entry is younger than everything resident; a freed entry drops out of all orderings.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (i_alloc_oh[i]) begin
            r_age[i][j] <= 1'b0;
          end else if (i_alloc_oh[j]) begin
            r_age[i][j] <= 1'b1;
          end else if (i_free_oh[i] || i_free_oh[j]) begin
            r_age[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_grant[i] = i_ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (i_ready[j] && r_age[j][i]) begin
          o_grant[i] = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/scalu_rs.sv
// Scalar-ALU reservation station: holds ops until both operands arrive, issues the oldest ready one.
module scalu_rs
  import scalu_rs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_valid,
  input  logic [OP_W-1:0]    disp_op,
  input  logic [ROBID_W-1:0] disp_robid,
  input  logic [RD_W-1:0]    disp_rd,
  input  logic               disp_op1_rdy,
  input  logic [XLEN-1:0]    disp_op1,
  input  logic               disp_op2_rdy,
  input  logic [XLEN-1:0]    disp_op2,
  output logic               rs_stall,
  input  logic               wb_valid,
  input  logic [ROBID_W-1:0] wb_robid,
  input  logic [XLEN-1:0]    wb_result,
  output logic               exers_scalu_issue,
  output logic [OP_W-1:0]    exers_scalu_op,
  output logic [ROBID_W-1:0] exers_robid,
  output logic [RD_W-1:0]    exers_rd,
  output logic [XLEN-1:0]    exers_op1,
  output logic [XLEN-1:0]    exers_op2,
  input  logic               scalu_stall,
  input  logic               rob_flush
);
  rs_entry_t        r_entries    [DEPTH];
  rs_entry_t        w_entry_next [DEPTH];
  rs_entry_t        w_disp_entry;
  rs_src_t          w_disp_src1, w_disp_src2;
  logic [DEPTH-1:0] w_valid, w_ready, w_alloc_oh, w_free_oh, w_grant;
  logic             w_disp_fire, w_found;

  assign rs_stall          = &w_valid;
  assign w_disp_fire       = disp_valid & ~rs_stall & ~rob_flush;
  assign exers_scalu_issue = |w_ready;
  assign w_free_oh         = w_grant & {DEPTH{~scalu_stall}};

  // Same-cycle writeback bypass so a dispatching op cannot miss its producer.
  assign w_disp_src1 = wake_src('{rdy: disp_op1_rdy, tag: disp_op1[ROBID_W-1:0], val: disp_op1},
                                wb_valid, wb_robid, wb_result);
  assign w_disp_src2 = wake_src('{rdy: disp_op2_rdy, tag: disp_op2[ROBID_W-1:0], val: disp_op2},
                                wb_valid, wb_robid, wb_result);
  assign w_disp_entry = '{valid: 1'b1, op: disp_op, robid: disp_robid, rd: disp_rd,
                          src1: w_disp_src1, src2: w_disp_src2};

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      assign w_valid[gi] = r_entries[gi].valid;
      assign w_ready[gi] = r_entries[gi].valid & r_entries[gi].src1.rdy & r_entries[gi].src2.rdy;
      assign w_entry_next[gi] = rob_flush      ? rs_entry_t'('0) :
                                w_alloc_oh[gi] ? w_disp_entry :
                                step_entry(r_entries[gi], w_free_oh[gi], wb_valid, wb_robid, wb_result);
    end
  endgenerate

  always_comb begin
    w_alloc_oh = '0;
    w_found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_valid[i] && !w_found) begin
        w_alloc_oh[i] = w_disp_fire;
        w_found       = 1'b1;
      end
    end
  end

  scalu_rs_age #(.DEPTH(DEPTH)) u_age (
    .clk        (clk),
    .rst        (rst),
    .i_alloc_oh (w_alloc_oh),
    .i_free_oh  (w_free_oh),
    .i_ready    (w_ready),
    .o_grant    (w_grant)
  );

  always_comb begin
    exers_scalu_op = '0;
    exers_robid    = '0;
    exers_rd       = '0;
    exers_op1      = '0;
    exers_op2      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_grant[i]) begin
        exers_scalu_op = r_entries[i].op;
        exers_robid    = r_entries[i].robid;
        exers_rd       = r_entries[i].rd;
        exers_op1      = r_entries[i].src1.val;
        exers_op2      = r_entries[i].src2.val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= rs_entry_t'('0);
      end
    end else begin
      r_entries <= w_entry_next;
    end
  end
endmodule

// File: tb/tb_scalu_rs.sv
// Scoreboard bench for scalu_rs: a dispatch-ordered queue model predicts issues and full/empty flags.
`timescale 1ns/1ps
module tb_scalu_rs;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_valid = 1'b0;
  logic [4:0]  disp_op = '0;
  logic [6:0]  disp_robid = '0;
  logic [5:0]  disp_rd = '0;
  logic        disp_op1_rdy = 1'b0;
  logic [31:0] disp_op1 = '0;
  logic        disp_op2_rdy = 1'b0;
  logic [31:0] disp_op2 = '0;
  logic        rs_stall;
  logic        wb_valid = 1'b0;
  logic [6:0]  wb_robid = '0;
  logic [31:0] wb_result = '0;
  logic        exers_scalu_issue;
  logic [4:0]  exers_scalu_op;
  logic [6:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1, exers_op2;
  logic        scalu_stall = 1'b0;
  logic        rob_flush = 1'b0;

  always #5 clk = ~clk;

  scalu_rs #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_robid(disp_robid), .disp_rd(disp_rd),
    .disp_op1_rdy(disp_op1_rdy), .disp_op1(disp_op1), .disp_op2_rdy(disp_op2_rdy), .disp_op2(disp_op2),
    .rs_stall(rs_stall), .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_result(wb_result),
    .exers_scalu_issue(exers_scalu_issue), .exers_scalu_op(exers_scalu_op), .exers_robid(exers_robid),
    .exers_rd(exers_rd), .exers_op1(exers_op1), .exers_op2(exers_op2),
    .scalu_stall(scalu_stall), .rob_flush(rob_flush)
  );

  typedef struct {
    logic [4:0] op; logic [6:0] robid; logic [5:0] rd;
    bit r1; logic [6:0] t1; logic [31:0] v1;
    bit r2; logic [6:0] t2; logic [31:0] v2;
  } ment_t;
  typedef struct { logic [4:0] op; logic [6:0] robid; logic [5:0] rd; logic [31:0] op1, op2; } txn_t;
  typedef struct { bit chk; bit stall; bit issue; bit txn_ok; } cyc_t;

  ment_t mq[$];   // resident ops, oldest first
  txn_t  txq[$];
  cyc_t  cq[$];
  int errors = 0, checks = 0, ntxn = 0;

  task automatic cycle(input bit chk, input bit rs, input bit fl, input bit stl,
                       input bit dv, input logic [6:0] robid,
                       input bit r1, input logic [31:0] o1, input bit r2, input logic [31:0] o2,
                       input bit wv, input logic [6:0] wr, input logic [31:0] wres);
    logic [4:0] op = 5'($urandom);
    logic [5:0] rd = 6'($urandom);
    int sel = -1;
    bit full;
    cyc_t c;
    ment_t n, m;
    txn_t t;
    rst = rs; rob_flush = fl; scalu_stall = stl;
    disp_valid = dv; disp_op = op; disp_robid = robid; disp_rd = rd;
    disp_op1_rdy = r1; disp_op1 = o1; disp_op2_rdy = r2; disp_op2 = o2;
    wb_valid = wv; wb_robid = wr; wb_result = wres;
    for (int i = 0; i < mq.size(); i++)
      if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
    full = (mq.size() == DEPTH);
    c.chk = chk; c.stall = full; c.issue = (sel >= 0); c.txn_ok = !rs && !fl;
    cq.push_back(c);
    if (rs || fl) begin
      mq.delete();
    end else begin
      if (sel >= 0 && !stl) begin
        t.op = mq[sel].op; t.robid = mq[sel].robid; t.rd = mq[sel].rd;
        t.op1 = mq[sel].v1; t.op2 = mq[sel].v2;
        txq.push_back(t);
        mq.delete(sel);
      end
      if (wv) begin
        for (int i = 0; i < mq.size(); i++) begin
          m = mq[i];
          if (!m.r1 && m.t1 == wr) begin m.r1 = 1'b1; m.v1 = wres; end
          if (!m.r2 && m.t2 == wr) begin m.r2 = 1'b1; m.v2 = wres; end
          mq[i] = m;
        end
      end
      if (dv && !full) begin
        n.op = op; n.robid = robid; n.rd = rd;
        n.t1 = o1[6:0]; n.r1 = r1 || (wv && o1[6:0] == wr); n.v1 = (!r1 && n.r1) ? wres : o1;
        n.t2 = o2[6:0]; n.r2 = r2 || (wv && o2[6:0] == wr); n.v2 = (!r2 && n.r2) ? wres : o2;
        mq.push_back(n);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k, input bit stl);
    for (int i = 0; i < k; i++) cycle(1, 0, 0, stl, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  cyc_t mc;
  txn_t mt;
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      mc = cq.pop_front();
      if (mc.chk) begin
        checks++;
        if (rs_stall !== mc.stall) begin
          errors++;
          $display("FAIL rs_stall @%0t: got %b want %b", $time, rs_stall, mc.stall);
        end
        checks++;
        if (exers_scalu_issue !== mc.issue) begin
          errors++;
          $display("FAIL issue_valid @%0t: got %b want %b", $time, exers_scalu_issue, mc.issue);
        end
        if (mc.txn_ok && exers_scalu_issue === 1'b1 && scalu_stall === 1'b0) begin
          checks++;
          if (txq.size() == 0) begin
            errors++;
            $display("FAIL issue_txn @%0t: got robid=%0d want no issue", $time, exers_robid);
          end else begin
            mt = txq.pop_front();
            ntxn++;
            if ({exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2} !==
                {mt.op, mt.robid, mt.rd, mt.op1, mt.op2}) begin
              errors++;
              $display("FAIL issue_txn @%0t: got op=%0d robid=%0d rd=%0d op1=%h op2=%h want op=%0d robid=%0d rd=%0d op1=%h op2=%h",
                       $time, exers_scalu_op, exers_robid, exers_rd, exers_op1, exers_op2,
                       mt.op, mt.robid, mt.rd, mt.op1, mt.op2);
            end else begin
              $display("txn %0d @%0t: robid=%0d op=%0d rd=%0d op1=%h op2=%h ok",
                       ntxn, $time, mt.robid, mt.op, mt.rd, mt.op1, mt.op2);
            end
          end
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Ready dispatch
    cycle(1, 0, 0, 0, 1, 7'd3, 1, 32'd5, 1, 32'd7, 0, 0, 0);
    idle(2, 0);
    // Wakeup, not issued before the broadcast
    cycle(1, 0, 0, 0, 1, 7'd4, 0, 32'd3, 1, 32'd1, 0, 0, 0);
    idle(2, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd3, 32'hDEADBEEF);
    idle(2, 0);
    // Dispatch/wakeup bypass
    cycle(1, 0, 0, 0, 1, 7'd5, 1, 32'd11, 0, 32'd9, 1, 7'd9, 32'd42);
    idle(2, 0);
    // Age order with a held stall
    cycle(1, 0, 0, 0, 1, 7'd10, 0, 32'd20, 1, 32'h1, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 7'd11, 0, 32'd21, 1, 32'h2, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 7'd12, 0, 32'd22, 1, 32'h3, 0, 0, 0);
    cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 7'd22, 32'hAAAA);
    cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 7'd20, 32'hBBBB);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      expect_val("stall_hold_robid", {25'd0, exers_robid}, 32'd10);
    end
    idle(2, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd21, 32'hCCCC);
    idle(2, 0);
    // Full station, dropped extra dispatch, release after one issue
    for (int i = 0; i < DEPTH; i++)
      cycle(1, 0, 0, 0, 1, 7'(40 + i), 0, 32'(50 + i), 1, 32'(i), 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 7'd60, 1, 32'd1, 1, 32'd2, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'd50, 32'h1234);
    idle(3, 0);
    cycle(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Flush then reset with five resident entries and a same-cycle dispatch
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++)
        cycle(1, 0, 0, 0, 1, 7'(70 + i), 0, 32'(80 + i), 0, 32'(90 + i), 0, 0, 0);
      cycle(1, k == 1, k == 0, 0, 1, 7'd99, 1, 32'd1, 1, 32'd2, 0, 0, 0);
      idle(2, 0);
    end
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r1 = 1'($urandom), r2 = 1'($urandom);
      cycle(1, 0, ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) < 7), 7'($urandom_range(0, 127)),
            r1, r1 ? $urandom : 32'($urandom_range(0, 15)),
            r2, r2 ? $urandom : 32'($urandom_range(0, 15)),
            1'($urandom), 7'($urandom_range(0, 15)), $urandom);
    end
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL txn_drain: got %0d unmatched expected issues want 0", txq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
